// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: parity modes, receiver states and
// the word format stored per received frame.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } rx_state_e;

    typedef struct packed {
        logic       parity_err;
        logic       frame_err;
        logic [7:0] data;
    } rx_word_t;

    localparam int OVERSAMPLE = 16;

    // Unused upper data bits are zero, so they do not disturb the reduction.
    function automatic logic parity_fail(input parity_e mode, input logic [7:0] data,
                                         input logic par_bit);
        logic w_sum;
        w_sum = (^data) ^ par_bit;
        return (mode == PAR_ODD) ? ~w_sum : w_sum;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO of received words; pointers carry one extra wrap bit so
// that the fill level is a plain pointer difference.
module uart_rx_fifo #(
    parameter int  DEPTH = 16,
    parameter type T     = uart_pkg::rx_word_t
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     i_push,
    input  T                         i_wdata,
    input  logic                     i_pop,
    output T                         o_rdata,
    output logic                     o_valid,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);

    T             r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic [AW:0]  w_level;
    logic         w_empty;
    logic         w_full;
    logic         w_pop;
    logic         w_push;

    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (w_level == (AW + 1)'(DEPTH));
    assign w_pop   = i_pop & ~w_empty;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign w_push  = i_push & (~w_full | w_pop);

    assign o_level = w_level;
    assign o_valid = ~w_empty;
    assign o_full  = w_full;
    assign o_rdata = w_empty ? T'('0) : r_mem[r_rd_ptr[AW-1:0]];

    // Read/write pointer update.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
        end
    end

    // Storage array write.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/uart_rx_monitor.sv
// UART receiver with 16x oversampling, parity/stop checking, break detection
// and a small FIFO of received words with error flags.
module uart_rx_monitor
    import uart_pkg::*;
#(
    parameter int      CLK_FREQ_HZ = 100_000_000,
    parameter int      BAUD_RATE   = 9600,
    parameter int      DATA_BITS   = 8,
    parameter parity_e PARITY      = PAR_NONE,
    parameter int      STOP_BITS   = 1,
    parameter int      FIFO_DEPTH  = 16
) (
    input  logic                          clk_i,
    input  logic                          reset_ni,
    input  logic                          rx_i,
    output logic [7:0]                    data_o,
    output logic                          frame_err_o,
    output logic                          parity_err_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic                          overrun_o,
    output logic                          break_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
    localparam int DIV   = CLK_FREQ_HZ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 1) begin : g_div_check
        $error("uart_rx_monitor: CLK_FREQ_HZ too low for BAUD_RATE*16");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_fmt_check
        $error("uart_rx_monitor: unsupported frame format");
    end

    logic             r_rx_meta, r_rx_sync, r_rx_prev;
    logic [DIV_W-1:0] r_div_cnt;
    logic [3:0]       r_tick_cnt;
    logic [2:0]       r_bit_cnt;
    rx_state_e        r_state;
    logic [7:0]       r_data;
    logic             r_par_bit, r_par_err, r_frame_err, r_stop_hi, r_wait_high;
    logic             r_break, r_overrun;

    logic     w_tick, w_start, w_sample, w_last_stop, w_frame_err, w_break;
    logic     w_full, w_pop, w_valid;
    rx_word_t w_word, w_head;

    assign w_tick      = (r_div_cnt == DIV_W'(DIV - 1));
    assign w_start     = (r_state == S_IDLE) & ~r_wait_high & r_rx_prev & ~r_rx_sync;
    assign w_sample    = w_tick & (r_tick_cnt == 4'd15);
    assign w_last_stop = (r_state == S_STOP) & w_sample & (r_bit_cnt == 3'(STOP_BITS - 1));
    assign w_frame_err = r_frame_err | ~r_rx_sync;
    // Break: every bit of the frame, including parity and all stop bits, was low.
    assign w_break     = w_last_stop & (r_data == 8'd0) & ~r_par_bit & ~r_stop_hi & ~r_rx_sync;
    assign w_pop       = w_valid & ready_i;
    assign w_word      = '{parity_err: r_par_err, frame_err: w_frame_err, data: r_data};

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Oversample divider, re-phased to the detected start edge.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_div_cnt <= '0;
        end else if (w_start || w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // Frame decoder state machine with registered event pulses.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_state     <= S_IDLE;
            r_tick_cnt  <= 4'd0;
            r_bit_cnt   <= 3'd0;
            r_data      <= 8'd0;
            r_par_bit   <= 1'b0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_stop_hi   <= 1'b0;
            r_wait_high <= 1'b0;
            r_break     <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_break   <= w_break;
            r_overrun <= w_last_stop & w_full & ~w_pop;
            case (r_state)
                S_IDLE: begin
                    if (r_rx_sync) r_wait_high <= 1'b0;
                    if (w_start) begin
                        r_state     <= S_START;
                        r_tick_cnt  <= 4'd0;
                        r_bit_cnt   <= 3'd0;
                        r_data      <= 8'd0;
                        r_par_bit   <= 1'b0;
                        r_par_err   <= 1'b0;
                        r_frame_err <= 1'b0;
                        r_stop_hi   <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (r_tick_cnt == 4'd7) begin
                            r_tick_cnt <= 4'd0;
                            r_state    <= r_rx_sync ? S_IDLE : S_DATA;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 4'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) r_tick_cnt <= r_tick_cnt + 4'd1;
                    if (w_sample) begin
                        r_data[r_bit_cnt] <= r_rx_sync;
                        if (r_bit_cnt == 3'(DATA_BITS - 1)) begin
                            r_bit_cnt <= 3'd0;
                            r_state   <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_tick) r_tick_cnt <= r_tick_cnt + 4'd1;
                    if (w_sample) begin
                        r_par_bit <= r_rx_sync;
                        r_par_err <= parity_fail(PARITY, r_data, r_rx_sync);
                        r_state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_tick) r_tick_cnt <= r_tick_cnt + 4'd1;
                    if (w_sample) begin
                        r_frame_err <= w_frame_err;
                        r_stop_hi   <= r_stop_hi | r_rx_sync;
                        if (w_last_stop) begin
                            r_bit_cnt   <= 3'd0;
                            r_state     <= S_IDLE;
                            r_wait_high <= w_frame_err;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (rx_word_t)
    ) u_fifo (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .i_push   (w_last_stop),
        .i_wdata  (w_word),
        .i_pop    (w_pop),
        .o_rdata  (w_head),
        .o_valid  (w_valid),
        .o_full   (w_full),
        .o_level  (fifo_level_o)
    );

    assign data_o       = w_head.data;
    assign frame_err_o  = w_head.frame_err;
    assign parity_err_o = w_head.parity_err;
    assign valid_o      = w_valid;
    assign overrun_o    = r_overrun;
    assign break_o      = r_break;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed bench for uart_rx_monitor: an 8N1 instance and a 7E1 instance,
// both at 16 clocks per bit with a 4-deep FIFO.
module tb_uart_rx_monitor;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       reset_ni;
    logic       rx_a, rx_b, ready_a, ready_b;
    logic [7:0] data_a, data_b;
    logic       fe_a, fe_b, pe_a, pe_b, valid_a, valid_b;
    logic       ovr_a, ovr_b, brk_a, brk_b;
    logic [2:0] lvl_a, lvl_b;
    int         n_vec  = 0;
    int         n_miss = 0;
    int         lat;
    int         n_pulse;

    always #5 clk = ~clk;

    uart_rx_monitor #(
        .CLK_FREQ_HZ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(8),
        .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_a (
        .clk_i(clk), .reset_ni(reset_ni), .rx_i(rx_a), .data_o(data_a),
        .frame_err_o(fe_a), .parity_err_o(pe_a), .valid_o(valid_a), .ready_i(ready_a),
        .overrun_o(ovr_a), .break_o(brk_a), .fifo_level_o(lvl_a)
    );

    uart_rx_monitor #(
        .CLK_FREQ_HZ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(7),
        .PARITY(PAR_EVEN), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_b (
        .clk_i(clk), .reset_ni(reset_ni), .rx_i(rx_b), .data_o(data_b),
        .frame_err_o(fe_b), .parity_err_o(pe_b), .valid_o(valid_b), .ready_i(ready_b),
        .overrun_o(ovr_b), .break_o(brk_b), .fifo_level_o(lvl_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input bit to_b, input logic v);
        if (to_b) rx_b = v;
        else      rx_a = v;
        repeat (16) @(negedge clk);
    endtask

    // Drives start, data and optional parity, then leaves the line at stop level.
    task automatic send_frame(input bit to_b, input logic [7:0] d, input int nbits,
                              input bit has_par, input logic par_bit);
        drive_bit(to_b, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(to_b, d[i]);
        if (has_par) drive_bit(to_b, par_bit);
        if (to_b) rx_b = 1'b1;
        else      rx_a = 1'b1;
    endtask

    task automatic wait_valid(input bit to_b, output int cycles);
        cycles = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if ((to_b ? valid_b : valid_a) === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic pop_a();
        ready_a = 1'b1;
        @(negedge clk);
        ready_a = 1'b0;
    endtask

    initial begin
        reset_ni = 1'b0; rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b0; ready_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_data", 32'(data_a), 32'h00);
        check("rst_level", 32'(lvl_a), 32'd0);
        check("rst_flags", 32'({fe_a, pe_a, ovr_a, brk_a}), 32'd0);
        reset_ni = 1'b1;
        repeat (5) @(negedge clk);

        // 8N1 0xA5 with the consumer always ready
        ready_a = 1'b1;
        send_frame(1'b0, 8'hA5, 8, 1'b0, 1'b0);
        wait_valid(1'b0, lat);
        check("a5_latency", 32'(lat), 32'd11);
        check("a5_data", 32'(data_a), 32'hA5);
        check("a5_flags", 32'({fe_a, pe_a}), 32'd0);
        @(negedge clk);
        check("a5_one_cycle", 32'(valid_a), 32'd0);
        ready_a = 1'b0;

        // 7E1: 0x55 has four ones, so the even parity bit is 0
        send_frame(1'b1, 8'h55, 7, 1'b1, 1'b1);
        wait_valid(1'b1, lat);
        check("par_bad_seen", 32'(lat != 0), 32'd1);
        check("par_bad_data", 32'(data_b), 32'h55);
        check("par_bad_flags", 32'({pe_b, fe_b}), 32'b10);
        ready_b = 1'b1; @(negedge clk); ready_b = 1'b0;
        repeat (16) @(negedge clk);
        send_frame(1'b1, 8'h55, 7, 1'b1, 1'b0);
        wait_valid(1'b1, lat);
        check("par_ok_data", 32'(data_b), 32'h55);
        check("par_ok_flags", 32'({pe_b, fe_b}), 32'b00);
        check("par_ok_level", 32'(lvl_b), 32'd1);
        ready_b = 1'b1; @(negedge clk); ready_b = 1'b0;

        // Fill to 4 with no consumer; fifth frame overruns
        for (int k = 1; k <= 4; k++) begin
            send_frame(1'b0, 8'(k), 8, 1'b0, 1'b0);
            repeat (20) @(negedge clk);
        end
        check("fill_level", 32'(lvl_a), 32'd4);
        send_frame(1'b0, 8'h05, 8, 1'b0, 1'b0);
        n_pulse = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ovr_a) n_pulse++;
        end
        check("ovr_pulses", 32'(n_pulse), 32'd1);
        check("ovr_level", 32'(lvl_a), 32'd4);
        for (int k = 1; k <= 4; k++) begin
            check("drain_data", 32'(data_a), 32'(k));
            pop_a();
        end
        check("drain_level", 32'(lvl_a), 32'd0);
        ready_a = 1'b1;
        repeat (3) @(negedge clk);
        check("underflow_level", 32'(lvl_a), 32'd0);
        check("underflow_valid", 32'(valid_a), 32'd0);
        ready_a = 1'b0;

        // Full FIFO with pop coinciding with push: no overrun, level unchanged
        for (int k = 1; k <= 4; k++) begin
            send_frame(1'b0, 8'h10 + 8'(k), 8, 1'b0, 1'b0);
            repeat (20) @(negedge clk);
        end
        send_frame(1'b0, 8'h15, 8, 1'b0, 1'b0);
        n_pulse = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 10) ready_a = 1'b1;
            if (i == 11) ready_a = 1'b0;
            if (ovr_a) n_pulse++;
        end
        check("full_pp_ovr", 32'(n_pulse), 32'd0);
        check("full_pp_level", 32'(lvl_a), 32'd4);
        check("full_pp_head", 32'(data_a), 32'h12);

        // Reset in the middle of bit 4 of a frame, then a clean 0x3C
        rx_a = 1'b0;
        repeat (16 + 4 * 16 + 8) @(negedge clk);
        reset_ni = 1'b0; rx_a = 1'b1;
        repeat (3) @(negedge clk);
        reset_ni = 1'b1;
        check("midrst_level", 32'(lvl_a), 32'd0);
        repeat (20) @(negedge clk);
        send_frame(1'b0, 8'h3C, 8, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check("midrst_count", 32'(lvl_a), 32'd1);
        check("midrst_data", 32'(data_a), 32'h3C);
        check("midrst_flags", 32'({fe_a, pe_a}), 32'd0);
        pop_a();

        // 6-clock glitch is rejected
        rx_a = 1'b0;
        repeat (6) @(negedge clk);
        rx_a = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_level", 32'(lvl_a), 32'd0);
        check("glitch_state", 32'(dut_a.r_state), 32'(S_IDLE));

        // 20-bit break: one entry, one break pulse
        rx_a = 1'b0;
        n_pulse = 0;
        for (int i = 0; i < 320; i++) begin
            @(negedge clk);
            if (brk_a) n_pulse++;
        end
        rx_a = 1'b1;
        repeat (40) @(negedge clk);
        check("brk_pulses", 32'(n_pulse), 32'd1);
        check("brk_level", 32'(lvl_a), 32'd1);
        check("brk_data", 32'(data_a), 32'h00);
        check("brk_flags", 32'({fe_a, pe_a}), 32'b10);
        check("b_idle_events", 32'({ovr_b, brk_b}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/uart_rx_monitor.md
UART_RX_MONITOR -- requirements
Module: uart_rx_monitor

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, line bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, legal 5..8, payload bits per frame.
REQ-004 SHALL have parameter PARITY, default PAR_NONE, values PAR_NONE/PAR_EVEN/PAR_ODD.
REQ-005 SHALL have parameter STOP_BITS, default 1, legal 1..2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, a power of two ≥2.
REQ-007 SHALL have port clk_i, input, 1, the only clock; all logic on its rising edge.
REQ-008 SHALL have port reset_ni, input, 1, reset; synchronous and active-low.
REQ-009 SHALL have port rx_i, input, 1, asynchronous UART line, idle high.
REQ-010 SHALL have port data_o, output, 8, FIFO head payload, LSB-aligned, upper bits zero when DATA_BITS<8.
REQ-011 SHALL have port frame_err_o, output, 1, stop-bit error flag of the head entry.
REQ-012 SHALL have port parity_err_o, output, 1, parity error flag of the head entry; 0 when PARITY=PAR_NONE.
REQ-013 SHALL have port valid_o, output, 1, FIFO not empty.
REQ-014 SHALL have port ready_i, input, 1, consumer accept; pop when valid_o && ready_i.
REQ-015 SHALL have port overrun_o, output, 1, one-cycle pulse when a completed frame is dropped.
REQ-016 SHALL have port break_o, output, 1, one-cycle pulse on a frame whose data, parity and stop bits are all 0.
REQ-017 SHALL have port fifo_level_o, output, $clog2(FIFO_DEPTH)+1, current entry count.

Function
REQ-018 SHALL pass rx_i through a 2-flop synchroniser; reset value of both flops 1.
REQ-019 SHALL generate a 16x oversample tick every DIV = CLK_FREQ_HZ/(BAUD_RATE*16) clocks, integer-truncated; DIV<1 is an elaboration error.
REQ-020 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-021 IDLE→START on a synchronised 1→0 transition; the tick counter restarts at that cycle.
REQ-022 START: at tick 8 sample; low → DATA, high → IDLE with nothing pushed (glitch reject).
REQ-023 DATA: sample every 16 ticks, LSB first, DATA_BITS samples; then PARITY if PARITY≠PAR_NONE, else STOP.
REQ-024 PARITY: one sample; even requires XOR(data,parity)=0, odd requires 1; mismatch sets parity_err.
REQ-025 STOP: STOP_BITS samples 16 ticks apart; any low sets frame_err; after the last sample push {parity_err,frame_err,data} and go to IDLE.
REQ-026 Frame errors SHALL NOT suppress the push; errored frames are stored with flags.
REQ-027 After a frame_err the FSM SHALL stay in IDLE until the line is seen high, so no false start occurs during a break.
REQ-028 Push latency: entry visible on valid_o/data_o the cycle after the final stop sample.
REQ-029 Full FIFO with no pop that cycle: drop the new frame, pulse overrun_o; existing contents unchanged.
REQ-030 Full FIFO with a pop in the same cycle as a push: both occur, no overrun, level unchanged.
REQ-031 Empty FIFO: ready_i ignored, level stays 0, no underflow.
REQ-032 FIFO pointers SHALL wrap modulo FIFO_DEPTH; level derived from pointers.

Reset
REQ-033 reset_ni low at a rising edge SHALL force: FSM IDLE, tick/bit counters 0, FIFO empty, valid_o 0, data_o 0, frame_err_o 0, parity_err_o 0, overrun_o 0, break_o 0, fifo_level_o 0.
REQ-034 Reset mid-frame SHALL discard the partial frame; the next start edge after release is decoded normally.

Structure
REQ-035 uart_pkg SHALL hold the parity_e enum (PAR_NONE/PAR_EVEN/PAR_ODD), the rx_state_e enum and the rx_word_t struct {parity_err, frame_err, data[7:0]}.
REQ-036 The FIFO SHALL be the sub-module uart_rx_fifo (parametrised on depth and rx_word_t), reused elsewhere in the SoC.

Verification
REQ-037 All scenarios use CLK_FREQ_HZ=1_600_000, BAUD_RATE=100_000 (DIV=1, 16 clk/bit), FIFO_DEPTH=4.
REQ-038 8N1 frame 0xA5, ready_i=1 -> valid_o high one cycle with data_o=0xA5, both flags 0.
REQ-039 DATA_BITS=7, PAR_EVEN, send 0x55 with wrong parity bit -> data_o=0x55, parity_err_o=1; correct parity -> 0.
REQ-040 ready_i=0, send 5 frames 0x01..0x05 -> level 4, overrun_o one pulse on frame 5; drain returns 0x01..0x04 in order.
REQ-041 6-clock low glitch on idle line -> no push, FSM back to IDLE; 20-bit low break -> break_o pulse, frame_err_o=1, data_o=0x00, a single entry.
REQ-042 reset_ni low at bit 4 of a frame, release, send 0x3C -> only 0x3C received, no error flags.
